rand_num: RTL and testbench
===========================

RAND_NUM -- requirements
Module: rand_num

Interface
REQ-001 SHALL have parameter WIDTH, default 8: LFSR width, legal range 4..16.
REQ-002 SHALL have parameter TAPS, default 8'hB8: Galois feedback mask, WIDTH bits wide; the default is maximal-length for WIDTH=8.
REQ-003 SHALL have parameter STEP_CYCLES, default 50_000_000: clocks between LFSR advances (0.5 s at 100 MHz); minimum 2.
REQ-004 SHALL have parameter REFRESH_CYCLES, default 16_384: clocks each display digit stays enabled; minimum 2.
REQ-005 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port set, input, 1 bit: level-sensitive seed load.
REQ-008 SHALL have port seed, input, WIDTH bits: seed value.
REQ-009 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port an, output, 4 bits: active-low digit enables; an[0] is the rightmost digit.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.

Function
REQ-012 State SHALL be held in a WIDTH-bit register lfsr.
- Each cycle, priority is rst > set > step.
REQ-013 While set=1, each cycle SHALL load lfsr with seed.
- If seed=0, 1 SHALL be loaded instead, avoiding the all-zero lockup.
- set=1 SHALL also clear the step counter.
REQ-014 Step counter behaviour:
- Counts 0..STEP_CYCLES-1 and wraps.
- On the wrap cycle, with set=0, lfsr SHALL advance once.
- Advance rule: lfsr_next = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
REQ-015 With the defaults, the sequence from 0x01 SHALL be: 0xB8, 0x5C, 0x2E, 0x17, 0xB3, ...
- Period SHALL be 255 and SHALL never reach 0.
REQ-016 lfsr SHALL be displayed in hex, one nibble per digit: digit i shows lfsr[4i+3:4i].
- Digits with index >= ceil(WIDTH/4) SHALL be blank: an bit held 1.
- A partial top nibble SHALL be zero-extended.
REQ-017 Display scan counter:
- Counts 0..REFRESH_CYCLES-1.
- On wrap, digit index advances 0->1->2->3->0.
- an SHALL be one-hot low for the current digit, or 4'b1111 if that digit is blank.
REQ-018 seg SHALL encode the current digit nibble as follows:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, active-low).
REQ-019 seg and an SHALL be registered.
- They reflect lfsr and the digit index with exactly one clock of latency.
- A changed lfsr value SHALL appear on the next displayed refresh of the affected digit.
REQ-020 dp SHALL be constant 1 (off).
REQ-021 A change of seed while set=0 SHALL have no effect.
REQ-022 Releasing set SHALL restart stepping: the first advance occurs exactly STEP_CYCLES cycles after the first cycle with set=0.

Reset
REQ-023 On a clock edge with rst=1 (including mid-operation, and overriding set):
- lfsr=1
- step counter=0, scan counter=0, digit index=0
- an=4'b1111, seg=7'h7F, dp=1
REQ-024 On the first clock after rst falls, an=4'b1110 and seg shows digit 0 of lfsr=0x01 (7'h79).

Verification
REQ-025 Reset then idle, STEP_CYCLES=4, REFRESH_CYCLES=2, set=0 -> lfsr steps every 4 clocks: 0x01, 0xB8, 0x5C, 0x2E; an cycles 1110/1101 only (an[3:2]=11 for WIDTH=8).
REQ-026 set=1 with seed=0 for 200 ns -> lfsr=0x01 held; no stepping while set=1.
REQ-027 seed=68 (0x44), set pulsed 200 ns -> lfsr=0x44 during set; digit0 and digit1 seg=7'h19; first advance STEP_CYCLES clocks after release gives 0x22.
REQ-028 seed changed to 0x10 while set=0 -> lfsr sequence unaffected.
REQ-029 rst asserted mid-sequence while set=1 -> next edge lfsr=1, an=1111, seg=7F; set's seed load resumes the cycle after rst falls.
REQ-030 Run 255 steps from any nonzero seed -> returns to the seed; the value 0 never occurs; dp=1 throughout.

Source files
------------

// File: rtl/rand_num.sv
// ---------------------------------------------------------------------------
// rand_num
//   Galois LFSR pseudo-random number generator whose state is shown in hex on
//   a 4-digit, multiplexed, active-low seven-segment display.
//
//   The LFSR advances once every STEP_CYCLES clocks. While `set` is high the
//   register is loaded with `seed` every cycle. A zero seed is replaced by 1,
//   because the all-zero state is a lockup state.
//   The display scans one digit every REFRESH_CYCLES clocks. Digit i shows
//   lfsr[4i+3:4i]. Digits above the LFSR width are blanked.
//
// Parameters
//   WIDTH          LFSR width, 4..16
//   TAPS           Galois feedback mask (WIDTH bits)
//   STEP_CYCLES    clocks between LFSR advances (>= 2)
//   REFRESH_CYCLES clocks each digit stays enabled (>= 2)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset
//   set   in   level-sensitive seed load
//   seed  in   seed value, WIDTH bits
//   seg   out  active-low segments {g,f,e,d,c,b,a}, registered
//   an    out  active-low digit enables, an[0] = rightmost, registered
//   dp    out  active-low decimal point, always off
// ---------------------------------------------------------------------------
module rand_num #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] TAPS           = 8'hB8,
  parameter int               STEP_CYCLES    = 50_000_000,
  parameter int               REFRESH_CYCLES = 16_384
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [WIDTH-1:0] seed,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp
);

  localparam int STEP_W     = (STEP_CYCLES    > 1) ? $clog2(STEP_CYCLES)    : 1;
  localparam int SCAN_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int NUM_DIGITS = (WIDTH + 3) / 4;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_CYCLES - 1);

  logic [WIDTH-1:0]  r_lfsr;
  logic [STEP_W-1:0] r_step_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit;
  logic [6:0]        r_seg;
  logic [3:0]        r_an;

  logic [WIDTH-1:0]  w_lfsr_next;
  logic [WIDTH-1:0]  w_seed_safe;
  logic              w_step_wrap;
  logic [15:0]       w_lfsr_ext;
  logic [3:0]        w_nibble;
  logic              w_blank;
  logic [6:0]        w_seg;
  logic [3:0]        w_an;

  // Galois advance: shift right, and fold the taps in when a 1 shifts out.
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_seed_safe = (seed == '0) ? WIDTH'(1) : seed;
  assign w_step_wrap = (r_step_cnt == STEP_LAST);

  // Seed load and step timing. Priority: rst > set > step.
  // NOTE: state registers use non-blocking (<=) so that every flop samples
  // the pre-edge values. Blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr     <= WIDTH'(1);
      r_step_cnt <= '0;
    end else if (set) begin
      r_lfsr     <= w_seed_safe;
      r_step_cnt <= '0;
    end else if (w_step_wrap) begin
      r_lfsr     <= w_lfsr_next;
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

  // Digit scan. It runs independently of set so the display keeps refreshing
  // while a seed is being loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt <= '0;
      r_digit    <= r_digit + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Zero-extend the LFSR into four nibbles so that a partial top nibble and
  // unused digits read as zero.
  always_comb begin
    w_lfsr_ext              = '0;
    w_lfsr_ext[WIDTH-1:0]   = r_lfsr;
  end

  assign w_nibble = w_lfsr_ext[{r_digit, 2'b00} +: 4];
  assign w_blank  = (int'(r_digit) >= NUM_DIGITS);

  // NOTE: every always_comb output gets a default before the case. Without the
  // default, a missed branch would infer a latch.
  always_comb begin
    w_seg = 7'h7F;
    w_an  = 4'b1111;
    if (!w_blank) begin
      w_an          = 4'b1111;
      w_an[r_digit] = 1'b0;
      unique case (w_nibble)
        4'h0: w_seg = 7'h40;
        4'h1: w_seg = 7'h79;
        4'h2: w_seg = 7'h24;
        4'h3: w_seg = 7'h30;
        4'h4: w_seg = 7'h19;
        4'h5: w_seg = 7'h12;
        4'h6: w_seg = 7'h02;
        4'h7: w_seg = 7'h78;
        4'h8: w_seg = 7'h00;
        4'h9: w_seg = 7'h10;
        4'hA: w_seg = 7'h08;
        4'hB: w_seg = 7'h03;
        4'hC: w_seg = 7'h46;
        4'hD: w_seg = 7'h21;
        4'hE: w_seg = 7'h06;
        4'hF: w_seg = 7'h0E;
        default: w_seg = 7'h7F;
      endcase
    end
  end

  // Registering the display outputs adds one clock of latency from lfsr and
  // digit, and keeps seg/an free of glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_rand_num.sv
// ---------------------------------------------------------------------------
// tb_rand_num
//   Directed bench for rand_num with WIDTH=8, TAPS=8'hB8, STEP_CYCLES=4 and
//   REFRESH_CYCLES=2. Each table record is applied for one rising edge, and the
//   result is compared on the following falling edge. Hand-written sequences
//   then cover seed load, step restart, reset during set, and the full period.
// ---------------------------------------------------------------------------
module tb_rand_num;

  logic       clk = 1'b0;
  logic       rst;
  logic       set;
  logic [7:0] seed;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_cmp  = 0;
  int n_fail = 0;

  rand_num #(
    .WIDTH         (8),
    .TAPS          (8'hB8),
    .STEP_CYCLES   (4),
    .REFRESH_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .set (set),
    .seed(seed),
    .seg (seg),
    .an  (an),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       set;
    logic [7:0] seed;
    logic [7:0] lfsr;
    logic [3:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One rising edge with the given inputs, then move to the falling edge
  // so that outputs are sampled away from the active edge.
  task automatic tick(input logic r, input logic s, input logic [7:0] sd);
    rst  = r;
    set  = s;
    seed = sd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic seen_d0, seen_d1, zero_seen, early_ret, dp_bad;

    //            rst   set   seed   lfsr   an       seg
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h01, 4'b1111, 7'h7F}; // reset
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 8'h01, 4'b1110, 7'h79}; // first clock out of reset
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 8'h01, 4'b1110, 7'h79};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 8'h01, 4'b1101, 7'h40};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 8'hB8, 4'b1101, 7'h40}; // 4th clock: step
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 8'hB8, 4'b1111, 7'h7F}; // digit 2 blank
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 8'hB8, 4'b1111, 7'h7F};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'hB8, 4'b1111, 7'h7F}; // digit 3 blank
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'h5C, 4'b1111, 7'h7F};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 8'h5C, 4'b1110, 7'h46}; // 'C'
    vecs[10] = '{1'b0, 1'b0, 8'h00, 8'h5C, 4'b1110, 7'h46};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 8'h5C, 4'b1101, 7'h12}; // '5'
    vecs[12] = '{1'b0, 1'b0, 8'h00, 8'h2E, 4'b1101, 7'h12};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h01, 4'b1111, 7'h7F}; // zero seed loads 1
    vecs[14] = '{1'b0, 1'b1, 8'h00, 8'h01, 4'b1111, 7'h7F};
    vecs[15] = '{1'b0, 1'b1, 8'h00, 8'h01, 4'b1111, 7'h7F};
    vecs[16] = '{1'b0, 1'b1, 8'h00, 8'h01, 4'b1111, 7'h7F};
    vecs[17] = '{1'b0, 1'b1, 8'h00, 8'h01, 4'b1110, 7'h79};

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].rst, vecs[i].set, vecs[i].seed);
      check($sformatf("vec%0d lfsr", i), 32'(dut.r_lfsr), 32'(vecs[i].lfsr));
      check($sformatf("vec%0d an", i),   32'(an),          32'(vecs[i].an));
      check($sformatf("vec%0d seg", i),  32'(seg),         32'(vecs[i].seg));
      check($sformatf("vec%0d dp", i),   32'(dp),          32'h1);
    end

    // While set stays high with a zero seed, the LFSR must not step.
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      check("hold_zero_seed", 32'(dut.r_lfsr), 32'h01);
    end

    // Load seed 0x44. Both visible digits must show '4' (7'h19).
    seen_d0 = 1'b0;
    seen_d1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 8'h44);
      check("seed44_lfsr", 32'(dut.r_lfsr), 32'h44);
      if (i > 0 && an == 4'b1110) begin
        seen_d0 = 1'b1;
        check("seed44_digit0", 32'(seg), 32'h19);
      end
      if (i > 0 && an == 4'b1101) begin
        seen_d1 = 1'b1;
        check("seed44_digit1", 32'(seg), 32'h19);
      end
    end
    check("seed44_digit0_shown", 32'(seen_d0), 32'h1);
    check("seed44_digit1_shown", 32'(seen_d1), 32'h1);

    // Release set. The first advance happens on the 4th edge with set=0.
    for (int i = 1; i <= 3; i++) begin
      tick(1'b0, 1'b0, 8'h44);
      check($sformatf("release_edge%0d", i), 32'(dut.r_lfsr), 32'h44);
    end
    tick(1'b0, 1'b0, 8'h44);
    check("release_first_step", 32'(dut.r_lfsr), 32'h22);

    // Changing the seed while set=0 must leave the sequence unchanged.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h10);
    check("seed_change_step1", 32'(dut.r_lfsr), 32'h11);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'h10);
    check("seed_change_step2", 32'(dut.r_lfsr), 32'hB0);

    // Reset has priority over set. The seed load resumes after reset drops.
    tick(1'b0, 1'b1, 8'h44);
    check("pre_rst_set", 32'(dut.r_lfsr), 32'h44);
    tick(1'b1, 1'b1, 8'h44);
    check("rst_over_set_lfsr", 32'(dut.r_lfsr), 32'h01);
    check("rst_over_set_an",   32'(an),          32'hF);
    check("rst_over_set_seg",  32'(seg),         32'h7F);
    tick(1'b0, 1'b1, 8'h44);
    check("after_rst_set_lfsr", 32'(dut.r_lfsr), 32'h44);
    check("after_rst_an",       32'(an),          32'hE);
    check("after_rst_seg",      32'(seg),         32'h79);

    // Full period from seed 0x44: 255 steps of 4 clocks each.
    zero_seen = 1'b0;
    early_ret = 1'b0;
    dp_bad    = 1'b0;
    for (int s = 1; s <= 255; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick(1'b0, 1'b0, 8'h44);
        if (dut.r_lfsr == 8'h00) zero_seen = 1'b1;
        if (dp !== 1'b1) dp_bad = 1'b1;
      end
      if (s < 255 && dut.r_lfsr == 8'h44) early_ret = 1'b1;
    end
    check("period_zero_seen",   32'(zero_seen),   32'h0);
    check("period_early_ret",   32'(early_ret),   32'h0);
    check("period_dp",          32'(dp_bad),      32'h0);
    check("period_return_seed", 32'(dut.r_lfsr), 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
